// File: rtl/demux_1x2_buf.sv
// 1-to-2 demultiplexer with a one-entry valid/ready buffer per output channel.
// Define DEMUX_AUTO_SEL_EN to ignore sel and alternate channels with an internal pointer.
module demux_1x2_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sel,
    output logic [WIDTH-1:0] out0,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready
);

    logic       active;
    logic       accept;
    logic [1:0] valid_vec;
    logic [1:0] ready_vec;
    logic [1:0] load_vec;

    assign ready_vec = {out1_ready, out0_ready};

`ifdef DEMUX_AUTO_SEL_EN
    logic ptr_reg;
    logic unused_sel;

    // Strict alternation: the pointer only advances when a word is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else if (accept) begin
            ptr_reg <= ~ptr_reg;
        end
    end

    assign active     = ptr_reg;
    assign unused_sel = sel;
`else
    assign active = sel;
`endif

    // A full buffer can still accept if it is being drained on the same edge.
    assign din_ready = !valid_vec[active] || ready_vec[active];
    assign accept    = din_valid && din_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : ch
            logic [WIDTH-1:0] data_reg;
            logic             valid_reg;

            assign load_vec[gi] = accept && (active == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (load_vec[gi]) begin
                    data_reg  <= din;
                    valid_reg <= 1'b1;
                end else if (valid_reg && ready_vec[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign valid_vec[gi] = valid_reg;
        end
    endgenerate

    assign out0       = ch[0].data_reg;
    assign out0_valid = valid_vec[0];
    assign out1       = ch[1].data_reg;
    assign out1_valid = valid_vec[1];

endmodule

// File: tb/tb_demux_1x2_buf.sv
// Self-checking bench for demux_1x2_buf: directed scenarios plus randomized traffic
// compared against a per-channel buffer model.
module tb_demux_1x2_buf;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sel;
    logic [WIDTH-1:0] out0;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1;
    logic             out1_valid;
    logic             out1_ready;

    int errors = 0;
    int checks = 0;

    // Reference model: each channel is a word plus a "holding" flag.
    logic [WIDTH-1:0] md [2];
    bit               mv [2];
    bit               mptr;
    bit               obs_rdy;
    bit               exp_rdy;

    demux_1x2_buf #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sel        (sel),
        .out0       (out0),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1       (out1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mchan();
`ifdef DEMUX_AUTO_SEL_EN
        return int'(mptr);
`else
        return int'(sel);
`endif
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            md[k] = '0;
            mv[k] = 1'b0;
        end
        mptr = 1'b0;
    endfunction

    // Drive one cycle of inputs from a negedge, advance the model at the posedge,
    // return at the following negedge so outputs can be sampled mid-cycle.
    task automatic step(input bit s, input logic [WIDTH-1:0] d, input bit dv,
                        input bit r0, input bit r1);
        int  c;
        bit  acc;
        bit  rdy [2];
        sel = s; din = d; din_valid = dv; out0_ready = r0; out1_ready = r1;
        #1;
        obs_rdy = din_ready;
        c = mchan();
        rdy[0] = r0; rdy[1] = r1;
        exp_rdy = !mv[c] || rdy[c];
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            acc = dv && exp_rdy;
            for (int k = 0; k < 2; k++) begin
                if (acc && k == c) begin
                    md[k] = d;
                    mv[k] = 1'b1;
                end else if (mv[k] && rdy[k]) begin
                    mv[k] = 1'b0;
                end
            end
            if (acc) mptr = ~mptr;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b/%b want 0/0", out0_valid, out1_valid);
        end
        checks++;
        if (out0 !== 8'h00 || out1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 00/00", out0, out1);
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", din_ready);
        end
        $display("test_reset: valids=%b%b data=%h/%h ready=%b", out1_valid, out0_valid, out1, out0, din_ready);
    endtask

    task automatic test_routing();
        step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out1 !== 8'hA5 || out1_valid !== 1'b1 || out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL routing: got out1=%h v1=%b v0=%b want out1=a5 v1=1 v0=0", out1, out1_valid, out0_valid);
        end
        $display("test_routing: out1=%h v1=%b v0=%b", out1, out1_valid, out0_valid);
    endtask

    task automatic test_backpressure();
        step(1'b0, 8'h11, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_rdy !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_ready[%0d]: got %b want 0", i, obs_rdy);
            end
            checks++;
            if (out0 !== 8'h11 || out0_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got %h v=%b want 11 v=1", i, out0, out0_valid);
            end
            $display("test_backpressure: cycle %0d ready=%b out0=%h", i, obs_rdy, out0);
        end
        // Switching sel while stalled must re-aim at the empty channel.
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_rdy !== 1'b1 || out1 !== 8'h22 || out1_valid !== 1'b1 || out0 !== 8'h11) begin
            errors++;
            $display("FAIL sel_switch: got rdy=%b out1=%h v1=%b out0=%h want 1 22 1 11", obs_rdy, out1, out1_valid, out0);
        end
        $display("test_sel_switch: ready=%b out1=%h out0=%h", obs_rdy, out1, out0);
    endtask

    task automatic test_throughput();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'(i), 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_rdy !== 1'b1 || out0 !== 8'(i) || out0_valid !== 1'b1) begin
                errors++;
                $display("FAIL throughput[%0d]: got rdy=%b out0=%h v=%b want 1 %h 1", i, obs_rdy, out0, out0_valid, 8'(i));
            end
            $display("test_throughput: word %0d out0=%h v=%b", i, out0, out0_valid);
        end
    endtask

    task automatic test_concurrency();
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h3C, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out1_valid !== 1'b0 || out0 !== 8'h3C || out0_valid !== 1'b1) begin
            errors++;
            $display("FAIL concurrency: got v1=%b out0=%h v0=%b want 0 3c 1", out1_valid, out0, out0_valid);
        end
        $display("test_concurrency: v1=%b out0=%h v0=%b", out1_valid, out0, out0_valid);
    endtask

`ifdef DEMUX_AUTO_SEL_EN
    task automatic test_auto_sel();
        step(1'b1, 8'h10, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out0 !== 8'h10 || out0_valid !== 1'b1) begin
            errors++;
            $display("FAIL auto_w0: got out0=%h v=%b want 10 1", out0, out0_valid);
        end
        step(1'b1, 8'h20, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out1 !== 8'h20 || out1_valid !== 1'b1) begin
            errors++;
            $display("FAIL auto_w1: got out1=%h v=%b want 20 1", out1, out1_valid);
        end
        step(1'b1, 8'h30, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out0 !== 8'h30 || out0_valid !== 1'b1) begin
            errors++;
            $display("FAIL auto_w2: got out0=%h v=%b want 30 1", out0, out0_valid);
        end
        $display("test_auto_sel: out0=%h out1=%h", out0, out1);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
            checks++;
            if (obs_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy);
            end
            checks++;
            if (out0 !== md[0] || out0_valid !== mv[0]) begin
                errors++;
                $display("FAIL rand_ch0[%0d]: got %h v=%b want %h v=%b", i, out0, out0_valid, md[0], mv[0]);
            end
            checks++;
            if (out1 !== md[1] || out1_valid !== mv[1]) begin
                errors++;
                $display("FAIL rand_ch1[%0d]: got %h v=%b want %h v=%b", i, out1, out1_valid, md[1], mv[1]);
            end
            $display("test_random[%0d]: sel=%b din=%h dv=%b rdy=%b out0=%h/%b out1=%h/%b",
                     i, sel, din, din_valid, obs_rdy, out0, out0_valid, out1, out1_valid);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        din_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0 !== 8'h00 || out1 !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %h/%b %h/%b want 00/0 00/0", out0, out0_valid, out1, out1_valid);
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_ready: got %b want 1", din_ready);
        end
        $display("test_async_reset: out0=%h/%b out1=%h/%b ready=%b", out0, out0_valid, out1, out1_valid, din_ready);
        @(negedge clk);
        step(1'b0, 8'h99, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out0_valid !== 1'b0 || obs_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: got v0=%b rdy=%b want 0 1", out0_valid, obs_rdy);
        end
        rst_n = 1'b1;
        step(1'b0, 8'h66, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out0 !== 8'h66 || out0_valid !== 1'b1 || out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got out0=%h v0=%b v1=%b want 66 1 0", out0, out0_valid, out1_valid);
        end
        $display("test_post_reset: out0=%h v0=%b", out0, out0_valid);
    endtask

    initial begin
        rst_n = 1'b0;
        din = '0; din_valid = 1'b0; sel = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        model_clear();
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DEMUX_AUTO_SEL_EN
        test_auto_sel();
`else
        test_routing();
        test_backpressure();
        test_throughput();
        test_concurrency();
`endif
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
